// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and whole-pipeline freeze across data-cache misses, plus saturating
// performance counters and a sticky miss-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_RS1_i,
  input  logic [4:0]       IF_ID_RS2_i,
  input  logic [4:0]       ID_EX_RD_i,
  input  logic             ID_EX_MemRead_i,
  input  logic             Branch_taken_i,
  input  logic             EX_MEM_MemReq_i,
  input  logic             dcache_hit_i,
  input  logic             dcache_fill_done_i,
  output logic             dcache_req_o,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             ID_EX_Bubble_o,
  output logic             IF_ID_Flush_o,
  output logic             Freeze_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {StRun, StMissWait, StReplay} state_e;

  // One extra bit so wait_q + 1 never wraps in the compare.
  localparam logic [10:0] TimeoutW = 11'(TIMEOUT);

  state_e           state_q, state_d;
  logic [9:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             err_q, err_d;

  logic load_use;
  logic req;
  logic freeze;
  logic miss_ev;

  // Load-use: EX holds a load whose destination feeds the instruction in ID.
  always_comb begin
    load_use = ID_EX_MemRead_i && (ID_EX_RD_i != 5'd0) &&
               ((ID_EX_RD_i == IF_ID_RS1_i) || (ID_EX_RD_i == IF_ID_RS2_i));
  end

  // Per-state cache request, freeze and miss detection (ignoring reset).
  always_comb begin
    req     = 1'b0;
    freeze  = 1'b0;
    miss_ev = 1'b0;
    unique case (state_q)
      StRun: begin
        req     = EX_MEM_MemReq_i;
        miss_ev = EX_MEM_MemReq_i && !dcache_hit_i;
        freeze  = miss_ev;
      end
      StMissWait: begin
        freeze = 1'b1;
      end
      StReplay: begin
        // MEM is frozen, so the original access is still there to retry.
        req     = 1'b1;
        miss_ev = !dcache_hit_i;
        freeze  = miss_ev;
      end
      default: ;
    endcase
  end

  // Next-state logic of the miss sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:      if (miss_ev) state_d = StMissWait;
      StMissWait: if (dcache_fill_done_i) state_d = StReplay;
      StReplay:   state_d = miss_ev ? StMissWait : StRun;
      default:    state_d = StRun;
    endcase
  end

  // Next values of the wait counter, timeout flag and performance counters.
  always_comb begin
    wait_d = wait_q;
    if (state_q == StMissWait) begin
      wait_d = (&wait_q) ? wait_q : wait_q + 10'd1;
    end else if (state_d == StMissWait) begin
      wait_d = '0;
    end

    err_d = err_q;
    if ((state_q == StMissWait) && (({1'b0, wait_q} + 11'd1) >= TimeoutW)) begin
      err_d = 1'b1;
    end

    stall_d = stall_q;
    if ((freeze || load_use) && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    miss_d = miss_q;
    if (miss_ev && !(&miss_q)) begin
      miss_d = miss_q + CNT_W'(1);
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      wait_q  <= '0;
      stall_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  // Pipeline control outputs: reset override, then freeze > load-use > flush.
  always_comb begin
    dcache_req_o   = 1'b0;
    Freeze_o       = 1'b0;
    PC_Write_o     = 1'b1;
    IF_ID_Write_o  = 1'b1;
    ID_EX_Bubble_o = 1'b0;
    IF_ID_Flush_o  = 1'b0;
    if (!rst_i) begin
      dcache_req_o = req;
      if (freeze) begin
        // A taken branch in ID persists and gets flushed after release.
        Freeze_o      = 1'b1;
        PC_Write_o    = 1'b0;
        IF_ID_Write_o = 1'b0;
      end else if (load_use) begin
        PC_Write_o     = 1'b0;
        IF_ID_Write_o  = 1'b0;
        ID_EX_Bubble_o = 1'b1;
      end else begin
        IF_ID_Flush_o = Branch_taken_i;
      end
    end
  end

  assign stall_cycles_o = stall_q;
  assign miss_cnt_o     = miss_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CW   = 5;
  localparam int unsigned TO   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1, rs2, rd;
  logic          mem_read, br, mem_req, hit, fill;
  logic          req_o, pcw_o, ifidw_o, bub_o, flush_o, frz_o, err_o;
  logic [CW-1:0] stall_o, miss_o;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_ctrl #(
    .CNT_W   (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .IF_ID_RS1_i        (rs1),
    .IF_ID_RS2_i        (rs2),
    .ID_EX_RD_i         (rd),
    .ID_EX_MemRead_i    (mem_read),
    .Branch_taken_i     (br),
    .EX_MEM_MemReq_i    (mem_req),
    .dcache_hit_i       (hit),
    .dcache_fill_done_i (fill),
    .dcache_req_o       (req_o),
    .PC_Write_o         (pcw_o),
    .IF_ID_Write_o      (ifidw_o),
    .ID_EX_Bubble_o     (bub_o),
    .IF_ID_Flush_o      (flush_o),
    .Freeze_o           (frz_o),
    .stall_cycles_o     (stall_o),
    .miss_cnt_o         (miss_o),
    .err_o              (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "waiting for refill" / "retrying after refill" flags,
  // integer counters, and the number of cycles spent waiting in this miss.
  bit m_wait = 0, m_retry = 0, m_known = 0, m_err = 0;
  int m_stall = 0, m_miss = 0, m_wcnt = 0;

  // Compare process: checks every output mid-cycle, then advances the model.
  initial begin
    bit lu, e_req, e_frz, e_mev;
    forever begin
      @(negedge clk);
      lu = mem_read && (rd != 0) && (rd == rs1 || rd == rs2);
      if (m_wait) begin
        e_req = 0; e_frz = 1;
      end else if (m_retry) begin
        e_req = 1; e_frz = !hit;
      end else begin
        e_req = mem_req; e_frz = mem_req && !hit;
      end
      e_mev = !m_wait && e_req && !hit;
      if (rst) begin
        chk("rst_req", req_o, 0);
        chk("rst_freeze", frz_o, 0);
        chk("rst_pcw", pcw_o, 1);
        chk("rst_ifidw", ifidw_o, 1);
        chk("rst_bubble", bub_o, 0);
        chk("rst_flush", flush_o, 0);
      end else begin
        chk("req", req_o, e_req);
        chk("freeze", frz_o, e_frz);
        chk("pcw", pcw_o, !e_frz && !lu);
        chk("ifidw", ifidw_o, !e_frz && !lu);
        chk("bubble", bub_o, !e_frz && lu);
        chk("flush", flush_o, !e_frz && !lu && br);
      end
      if (m_known) begin
        chk("stall_cnt", stall_o, m_stall);
        chk("miss_cnt", miss_o, m_miss);
        chk("err", err_o, m_err);
      end
      if (rst) begin
        m_wait = 0; m_retry = 0; m_known = 1; m_err = 0;
        m_stall = 0; m_miss = 0; m_wcnt = 0;
      end else begin
        if (e_frz || lu) m_stall = (m_stall < MAXC) ? m_stall + 1 : MAXC;
        if (e_mev) m_miss = (m_miss < MAXC) ? m_miss + 1 : MAXC;
        if (m_wait) begin
          m_wcnt++;
          if (m_wcnt >= TO) m_err = 1;
          if (fill) begin
            m_wait = 0; m_retry = 1;
          end
        end else if (e_mev) begin
          m_wait = 1; m_retry = 0; m_wcnt = 0;
        end else begin
          m_retry = 0;
        end
      end
    end
  end

  task automatic drive(input bit r, input bit mr, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input bit b, input bit mq, input bit h,
                       input bit f);
    rst = r; mem_read = mr; rd = d; rs1 = s1; rs2 = s2;
    br = b; mem_req = mq; hit = h; fill = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    // Reset with a miss pattern on the inputs: outputs must stay forced.
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("lit_rst_freeze", frz_o, 0);
    chk("lit_rst_req", req_o, 0);
    chk("lit_rst_pcw", pcw_o, 1);
    tick();
    tick();
    chk("lit_rst_stall", stall_o, 0);
    chk("lit_rst_miss", miss_o, 0);
    chk("lit_rst_err", err_o, 0);

    // Load-use with RD=5 matching RS1, then the same with RD=0.
    drive(0, 1, 5, 5, 0, 0, 0, 1, 0);
    #1;
    chk("lit_lu_pcw", pcw_o, 0);
    chk("lit_lu_ifidw", ifidw_o, 0);
    chk("lit_lu_bubble", bub_o, 1);
    tick();
    chk("lit_lu_stall", stall_o, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("lit_rd0_bubble", bub_o, 0);
    chk("lit_rd0_pcw", pcw_o, 1);
    tick();
    chk("lit_rd0_stall", stall_o, 1);

    // Miss at N, fill on N+10, replay hit on N+11, with a taken branch held in ID.
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
    #1;
    chk("lit_miss_freeze", frz_o, 1);
    chk("lit_miss_req", req_o, 1);
    chk("lit_miss_flush", flush_o, 0);
    tick();
    chk("lit_miss_cnt1", miss_o, 1);
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 0, 0, 0, 1, 1, 0, i == 10);
      #1;
      chk("lit_wait_freeze", frz_o, 1);
      chk("lit_wait_req", req_o, 0);
      chk("lit_wait_flush", flush_o, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 1, 1, 0);
    #1;
    chk("lit_rel_freeze", frz_o, 0);
    chk("lit_rel_req", req_o, 1);
    chk("lit_rel_flush", flush_o, 1);
    tick();
    chk("lit_rel_miss", miss_o, 1);
    chk("lit_rel_stall", stall_o, 11);
    idle();
    tick();

    // Replay that misses again goes straight back to waiting.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("lit_replay_miss_freeze", frz_o, 1);
    tick();
    chk("lit_replay_miss_cnt", miss_o, 2);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("lit_replay_wait_req", req_o, 0);
    chk("lit_replay_wait_freeze", frz_o, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();

    // Timeout: error appears after the fourth waiting cycle and is sticky.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick();
      chk("lit_timeout_err", err_o, (i >= 4) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    idle();
    tick();
    chk("lit_err_sticky", err_o, 1);
    do_reset();
    chk("lit_err_cleared", err_o, 0);

    // Reset while waiting aborts the miss; a late fill pulse does nothing.
    drive(0, 1, 3, 3, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("lit_midrst_freeze", frz_o, 0);
    chk("lit_midrst_req", req_o, 0);
    tick();
    chk("lit_midrst_stall", stall_o, 0);
    chk("lit_midrst_miss", miss_o, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("lit_late_fill_freeze", frz_o, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    #1;
    chk("lit_after_req", req_o, 1);
    chk("lit_after_freeze", frz_o, 0);
    tick();

    // Randomized traffic; small register indices make load-use hits common.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 40,
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 20);
      tick();
    end
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
